// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// Module   : aes_pkg
// Brief    : Shared AES-128 constants (S-boxes, Rcon), GF(2^8) helpers and
//            the core state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        KEY_WAIT = 2'd0,
        KEY_EXP  = 2'd1,
        IDLE     = 2'd2,
        ROUND    = 2'd3
    } aes_state_e;

    // Byte 0x00 sits in the top byte of each table.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Rcon[1] in the top byte through Rcon[10] in the bottom byte.
    localparam logic [79:0] c_rcon = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_sbox[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return c_inv_sbox[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [3:0] w_idx;
        w_idx = 4'd10 - i;
        return c_rcon[{w_idx, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] w_acc;
        logic [7:0] w_pow;
        w_acc = 8'h00;
        w_pow = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) w_acc = w_acc ^ w_pow;
            w_pow = xtime(w_pow);
        end
        return w_acc;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // rk[i] from rk[i-1]; i is the round-key index 1..10.
    function automatic logic [127:0] expand_round_key(input logic [127:0] prev, input logic [3:0] i);
        logic [31:0] w0, w1, w2, w3, w_t;
        w_t = sub_word(rot_word(prev[31:0])) ^ {rcon(i), 24'h000000};
        w0  = prev[127:96] ^ w_t;
        w1  = prev[95:64]  ^ w0;
        w2  = prev[63:32]  ^ w1;
        w3  = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_core_if.sv
//------------------------------------------------------------------------------
// Module   : aes_inv_core_if
// Brief    : Key/data ready-valid handshake bundle for the AES-128 inverse core.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface aes_inv_core_if;

    logic         key_ready;
    logic         key_valid;
    logic [127:0] main_key;
    logic         data_ready;
    logic         data_valid;
    logic [127:0] data_in;
    logic         data_out_valid;
    logic [127:0] data_out;

    modport master (
        input  key_ready, data_ready, data_out_valid, data_out,
        output key_valid, main_key, data_valid, data_in
    );

    modport slave (
        output key_ready, data_ready, data_out_valid, data_out,
        input  key_valid, main_key, data_valid, data_in
    );

endinterface

`default_nettype wire

// File: rtl/aes_inv_round.sv
//------------------------------------------------------------------------------
// Module   : aes_inv_round
// Brief    : One combinational inverse round: InvShiftRows, InvSubBytes,
//            AddRoundKey, then InvMixColumns unless i_last.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_last,
    output logic [127:0] o_state
);

    logic [127:0] w_sub;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // Row r rotates right by r, so output column c reads input column c-r.
            localparam int c_src = 4 * ((c - r + 4) % 4) + r;
            localparam int c_dst = 4 * c + r;
            assign w_sub[127 - 8*c_dst -: 8] = inv_sbox(i_state[127 - 8*c_src -: 8])
                                               ^ i_round_key[127 - 8*c_dst -: 8];
        end
        assign o_state[127 - 32*c -: 32] = i_last ? w_sub[127 - 32*c -: 32]
                                                  : inv_mix_column(w_sub[127 - 32*c -: 32]);
    end

endmodule

`default_nettype wire

// File: rtl/aes_inv_core.sv
//------------------------------------------------------------------------------
// Module   : aes_inv_core
// Brief    : Iterative AES-128 decryption core, one round per clock, with a
//            stored round-key table. Define AES_INV_REKEY_EN to allow a new
//            key to be accepted while idle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_inv_core
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    aes_inv_core_if.slave bus
);

    localparam logic [1:0] c_st_key_wait = KEY_WAIT;
    localparam logic [1:0] c_st_key_exp  = KEY_EXP;
    localparam logic [1:0] c_st_idle     = IDLE;
    localparam logic [1:0] c_st_round    = ROUND;
    localparam logic [3:0] c_last_rk     = 4'(NR);
    localparam logic [3:0] c_first_round = 4'(NR - 1);

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [3:0]   r_cnt;
    logic [127:0] r_rk [0:NR];
    logic [127:0] r_st;
    logic         r_key_ready;
    logic         r_data_ready;
    logic         r_out_valid;
    logic [127:0] r_out;

    logic         w_key_xfer;
    logic         w_data_xfer;
    logic         w_key_ready_nxt;
    logic [127:0] w_rk_next;
    logic [127:0] w_round_out;

    assign w_key_xfer  = r_key_ready  & bus.key_valid;
    // A key offered on the same edge takes priority over data.
    assign w_data_xfer = r_data_ready & bus.data_valid & ~w_key_xfer;

    assign w_rk_next = expand_round_key(r_rk[r_cnt - 4'd1], r_cnt);

    aes_inv_round u_round (
        .i_state     (r_st),
        .i_round_key (r_rk[r_cnt]),
        .i_last      (r_cnt == 4'd0),
        .o_state     (w_round_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_key_wait: if (w_key_xfer) w_state_nxt = c_st_key_exp;
            c_st_key_exp:  if (r_cnt == c_last_rk) w_state_nxt = c_st_idle;
            c_st_idle: begin
                if (w_key_xfer)       w_state_nxt = c_st_key_exp;
                else if (w_data_xfer) w_state_nxt = c_st_round;
            end
            c_st_round:    if (r_cnt == 4'd0) w_state_nxt = c_st_key_wait ^ c_st_idle;
            default:       w_state_nxt = c_st_key_wait;
        endcase
    end

`ifdef AES_INV_REKEY_EN
    assign w_key_ready_nxt = (w_state_nxt == c_st_key_wait) || (w_state_nxt == c_st_idle);
`else
    assign w_key_ready_nxt = (w_state_nxt == c_st_key_wait);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_key_wait;
            r_cnt        <= 4'd0;
            r_st         <= 128'd0;
            r_key_ready  <= 1'b0;
            r_data_ready <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out        <= 128'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_key_ready  <= w_key_ready_nxt;
            r_data_ready <= (w_state_nxt == c_st_idle);
            r_out_valid  <= 1'b0;
            case (r_state)
                c_st_key_wait: if (w_key_xfer) r_cnt <= 4'd1;
                c_st_key_exp:  r_cnt <= (r_cnt == c_last_rk) ? 4'd0 : r_cnt + 4'd1;
                c_st_idle: begin
                    if (w_key_xfer) begin
                        r_cnt <= 4'd1;
                    end else if (w_data_xfer) begin
                        r_st  <= bus.data_in ^ r_rk[NR];
                        r_cnt <= c_first_round;
                    end
                end
                c_st_round: begin
                    r_st <= w_round_out;
                    if (r_cnt == 4'd0) begin
                        r_out       <= w_round_out;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_cnt <= 4'd0;
            endcase
        end
    end

    // Round-key storage carries no reset; the FSM never reads it before a key load.
    always_ff @(posedge clk) begin
        if (w_key_xfer) begin
            r_rk[0] <= bus.main_key;
        end else if (r_state == c_st_key_exp) begin
            r_rk[r_cnt] <= w_rk_next;
        end
    end

    assign bus.key_ready      = r_key_ready;
    assign bus.data_ready     = r_data_ready;
    assign bus.data_out_valid = r_out_valid;
    assign bus.data_out       = r_out;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_core.sv
//------------------------------------------------------------------------------
// Module   : tb_aes_inv_core
// Brief    : Self-checking bench for aes_inv_core against an arithmetic AES
//            reference model; covers AES_INV_REKEY_EN when defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_inv_core;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    aes_inv_core_if bus ();

    aes_inv_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] c_c1_key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_c1_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_c1_pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_b_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_b_rk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_b_ct   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_b_pt   = 128'h3243f6a8885a308d313198a2e0370734;

    // ---------------- reference model ----------------
    logic [7:0] m_sbox  [256];
    logic [7:0] m_isbox [256];

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            m_sbox[x]  = b;
            m_isbox[b] = 8'(x);
        end
    endtask

    function automatic logic [127:0] m_round_key(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    function automatic logic [127:0] m_decrypt(input logic [127:0] key, input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk, res;
        rk = m_round_key(key, 10);
        for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ rk[127 - 8*i -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            rk = m_round_key(key, rnd);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*c] = m_isbox[s[r + 4*((c - r + 4) % 4)]] ^ rk[127 - 8*(r + 4*c) -: 8];
            for (int c = 0; c < 4; c++) begin
                if (rnd > 0) begin
                    s[4*c+0] = m_mul(t[4*c],8'h0e)^m_mul(t[4*c+1],8'h0b)^m_mul(t[4*c+2],8'h0d)^m_mul(t[4*c+3],8'h09);
                    s[4*c+1] = m_mul(t[4*c],8'h09)^m_mul(t[4*c+1],8'h0e)^m_mul(t[4*c+2],8'h0b)^m_mul(t[4*c+3],8'h0d);
                    s[4*c+2] = m_mul(t[4*c],8'h0d)^m_mul(t[4*c+1],8'h09)^m_mul(t[4*c+2],8'h0e)^m_mul(t[4*c+3],8'h0b);
                    s[4*c+3] = m_mul(t[4*c],8'h0b)^m_mul(t[4*c+1],8'h0d)^m_mul(t[4*c+2],8'h09)^m_mul(t[4*c+3],8'h0e);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- checking and stimulus ----------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.key_valid  = 1'b0;
        bus.data_valid = 1'b0;
        repeat (3) tick();
        chk({tag, "_kr"},   128'(bus.key_ready), 128'(0));
        chk({tag, "_dr"},   128'(bus.data_ready), 128'(0));
        chk({tag, "_dov"},  128'(bus.data_out_valid), 128'(0));
        chk({tag, "_dout"}, bus.data_out, 128'd0);
        rst = 1'b0;
        tick();
        chk({tag, "_kr_rise"}, 128'(bus.key_ready), 128'(1));
    endtask

    task automatic load_key(input logic [127:0] key, input string tag);
        int n;
        bus.main_key  = key;
        bus.key_valid = 1'b1;
        n = 0;
        while (!bus.key_ready && n < 40) begin tick(); n++; end
        tick();
        bus.key_valid = 1'b0;
        chk({tag, "_kr_fall"}, 128'(bus.key_ready), 128'(0));
        n = 0;
        while (!bus.data_ready && n < 40) begin tick(); n++; end
        chk({tag, "_kexp_lat"}, 128'(n), 128'(10));
    endtask

    task automatic decrypt(input logic [127:0] ct, input logic [127:0] exp_pt,
                           input string tag, input bit key_noise);
        int n;
        bus.data_in    = ct;
        bus.data_valid = 1'b1;
        n = 0;
        while (!bus.data_ready && n < 40) begin tick(); n++; end
        tick();
        bus.data_valid = 1'b0;
        chk({tag, "_dr_fall"}, 128'(bus.data_ready), 128'(0));
        if (key_noise) begin
            bus.main_key  = rand128();
            bus.key_valid = 1'b1;
            chk({tag, "_kr_round"}, 128'(bus.key_ready), 128'(0));
        end
        n = 0;
        while (!bus.data_out_valid && n < 40) begin tick(); n++; end
        bus.key_valid = 1'b0;
        chk({tag, "_lat"},  128'(n), 128'(10));
        chk({tag, "_pt"},   bus.data_out, exp_pt);
        chk({tag, "_dr_hi"}, 128'(bus.data_ready), 128'(1));
        tick();
        chk({tag, "_pulse"}, 128'(bus.data_out_valid), 128'(0));
        chk({tag, "_hold"},  bus.data_out, exp_pt);
    endtask

    initial begin
        int n, nv;
        logic [127:0] key, ct;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.key_valid  = 1'b0;
        bus.data_valid = 1'b0;
        bus.main_key   = 128'd0;
        bus.data_in    = 128'd0;
        build_sbox();

        do_reset("rst0");

        // data offered during key wait/expansion must not be taken early
        bus.data_in    = c_c1_ct;
        bus.data_valid = 1'b1;
        load_key(c_c1_key, "c1");
        decrypt(c_c1_ct, c_c1_pt, "c1", 1'b0);
        for (int j = 0; j < 2; j++) begin
            ct = rand128();
            decrypt(ct, m_decrypt(c_c1_key, ct), $sformatf("c1_rnd%0d", j), 1'b1);
        end

        // reset while the block is in round r=5
        bus.data_in    = c_c1_ct;
        bus.data_valid = 1'b1;
        n = 0;
        while (!bus.data_ready && n < 40) begin tick(); n++; end
        tick();
        bus.data_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        nv = 0;
        repeat (12) begin tick(); if (bus.data_out_valid) nv++; end
        chk("mid_rst_nodov", 128'(nv), 128'(0));
        chk("mid_rst_dout", bus.data_out, 128'd0);
        chk("mid_rst_kr", 128'(bus.key_ready), 128'(0));
        chk("mid_rst_dr", 128'(bus.data_ready), 128'(0));
        rst = 1'b0;
        tick();
        chk("mid_rst_kr_rise", 128'(bus.key_ready), 128'(1));
        load_key(c_c1_key, "c1_re");
        decrypt(c_c1_ct, c_c1_pt, "c1_re", 1'b0);

        // FIPS-197 App. B
        do_reset("rst_b");
        load_key(c_b_key, "b");
        chk("b_rk10", dut.r_rk[10], c_b_rk10);
        decrypt(c_b_ct, c_b_pt, "b", 1'b0);

        // back-to-back with data_valid held high
        bus.data_in    = c_c1_ct;
        bus.data_valid = 1'b1;
        n = 0;
        while (!bus.data_ready && n < 40) begin tick(); n++; end
        tick();
        bus.data_in = c_b_ct;
        n = 0;
        while (!bus.data_out_valid && n < 40) begin tick(); n++; end
        chk("b2b_lat", 128'(n), 128'(10));
        chk("b2b_pt1", bus.data_out, m_decrypt(c_b_key, c_c1_ct));
        chk("b2b_dr1", 128'(bus.data_ready), 128'(1));
        tick();
        n = 1;
        while (!bus.data_out_valid && n < 40) begin tick(); n++; end
        bus.data_valid = 1'b0;
        chk("b2b_gap", 128'(n), 128'(11));
        chk("b2b_pt2", bus.data_out, c_b_pt);
        chk("b2b_dr2", 128'(bus.data_ready), 128'(1));
        tick();

`ifdef AES_INV_REKEY_EN
        load_key(c_c1_key, "rk_c1");
        bus.main_key   = c_b_key;
        bus.key_valid  = 1'b1;
        bus.data_in    = c_c1_ct;
        bus.data_valid = 1'b1;
        chk("rk_both_kr", 128'(bus.key_ready), 128'(1));
        chk("rk_both_dr", 128'(bus.data_ready), 128'(1));
        tick();
        bus.key_valid  = 1'b0;
        bus.data_valid = 1'b0;
        chk("rk_dr_fall", 128'(bus.data_ready), 128'(0));
        chk("rk_kr_fall", 128'(bus.key_ready), 128'(0));
        n = 0;
        nv = 0;
        while (!bus.data_ready && n < 40) begin
            tick();
            n++;
            if (bus.data_out_valid) nv++;
        end
        chk("rk_kexp_lat", 128'(n), 128'(10));
        chk("rk_no_data", 128'(nv), 128'(0));
        decrypt(c_b_ct, c_b_pt, "rk_b", 1'b0);
`endif

        // random keys and blocks against the model
        for (int k = 0; k < 2; k++) begin
            do_reset($sformatf("rst_r%0d", k));
            key = rand128();
            load_key(key, $sformatf("rk%0d", k));
            for (int j = 0; j < 2; j++) begin
                ct = rand128();
                decrypt(ct, m_decrypt(key, ct), $sformatf("rk%0d_blk%0d", k, j), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
